// File: rtl/bm_sched_pkg.sv
// Shared types and geometry helpers for the block-match dispatch scheduler.
// Geometry functions turn pixel dimensions into block counts and word offsets.
package bm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN
  } statetype;

  function automatic int unsigned blocks_per_row(input int unsigned frame_w,
                                                 input int unsigned srch_w,
                                                 input int unsigned blk_w);
    return (frame_w - srch_w) / blk_w;
  endfunction

  function automatic int unsigned blocks_per_col(input int unsigned frame_h,
                                                 input int unsigned srch_h,
                                                 input int unsigned blk_h);
    return (frame_h - srch_h) / blk_h;
  endfunction

  function automatic int unsigned row_step(input int unsigned frame_w,
                                           input int unsigned port_w,
                                           input int unsigned blk_h);
    return (frame_w / port_w) * blk_h;
  endfunction

  function automatic int unsigned right_off(input int unsigned frame_w,
                                            input int unsigned port_w,
                                            input int unsigned srch_h,
                                            input int unsigned blk_h);
    return (frame_w / port_w) * ((srch_h - blk_h) / 2);
  endfunction

  function automatic int unsigned left_off(input int unsigned frame_w,
                                           input int unsigned port_w,
                                           input int unsigned srch_w,
                                           input int unsigned srch_h,
                                           input int unsigned blk_w,
                                           input int unsigned blk_h);
    return right_off(frame_w, port_w, srch_h, blk_h) + srch_w / port_w - blk_w / port_w;
  endfunction

endpackage

// File: rtl/bm_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after ptr.
module bm_rr_pick #(
  parameter int unsigned NUM_ENG = 2,
  parameter int unsigned IdxW    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
  input  logic [NUM_ENG-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_ENG-1:0] gnt,
  output logic [IdxW-1:0]    gnt_idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      cand = IdxW'((32'(ptr) + i) % NUM_ENG);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bm_dispatch_sched.sv
// Frame scheduler: walks the block grid in raster order and hands each block to the
// next ready block-match engine round-robin; signals frame_done once all engines drain.
module bm_dispatch_sched
  import bm_sched_pkg::*;
#(
  parameter int unsigned NUM_ENG      = 2,
  parameter int unsigned rd_port_w    = 8,
  parameter int unsigned bit_frame_w  = 960,
  parameter int unsigned bit_frame_h  = 540,
  parameter int unsigned block_width  = 16,
  parameter int unsigned block_height = 16,
  parameter int unsigned search_blk_w = 64,
  parameter int unsigned search_blk_h = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             img_number_in,
  output logic                   sched_idle,
  output logic                   bm_working_buf,
  output logic                   frame_done,
  input  logic [NUM_ENG-1:0]     eng_done,
  output logic [NUM_ENG-1:0]     eng_start,
  output logic [NUM_ENG*16-1:0]  eng_srch_addr,
  output logic [NUM_ENG*16-1:0]  eng_blk_addr_left,
  output logic [NUM_ENG*16-1:0]  eng_blk_addr_right,
  output logic [NUM_ENG*16-1:0]  eng_blk_index
);

  localparam int unsigned IdxW     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int unsigned BlkAddrW = block_width / rd_port_w;
  localparam int unsigned BlocksPerRow =
      blocks_per_row(bit_frame_w, search_blk_w, block_width);
  localparam int unsigned BlocksPerCol =
      blocks_per_col(bit_frame_h, search_blk_h, block_height);
  localparam logic [14:0] RowStep  = 15'(row_step(bit_frame_w, rd_port_w, block_height));
  localparam logic [14:0] RightOff =
      15'(right_off(bit_frame_w, rd_port_w, search_blk_h, block_height));
  localparam logic [14:0] LeftOff  = 15'(left_off(bit_frame_w, rd_port_w, search_blk_w,
                                                  search_blk_h, block_width, block_height));
  localparam logic [14:0] SrchStep = 15'(BlkAddrW);
  localparam logic [5:0]  LastCol  = 6'(BlocksPerRow - 1);
  localparam logic [5:0]  LastRow  = 6'(BlocksPerCol - 1);

  statetype            state_q, state_d;
  logic [3:0]          img_q, img_d;
  logic                frame_done_q, frame_done_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [5:0]          row_q, row_d, col_q, col_d;
  logic [14:0]         srch_q, srch_d, row_base_q, row_base_d;
  logic [NUM_ENG-1:0]  pending_q, pending_d, busy_q, busy_d;
  logic [NUM_ENG-1:0]  ready, gnt, load;
  logic [IdxW-1:0]     gnt_idx;

  logic [NUM_ENG-1:0][15:0] srch_addr_q, left_q, right_q, index_q;

  // An engine that already saw its start but has not yet dropped eng_done is not ready.
  assign ready = eng_done & ~pending_q;

  bm_rr_pick #(
    .NUM_ENG (NUM_ENG),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req     (ready),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    img_d        = img_q;
    frame_done_d = 1'b0;
    ptr_d        = ptr_q;
    row_d        = row_q;
    col_d        = col_q;
    srch_d       = srch_q;
    row_base_d   = row_base_q;
    load         = '0;
    unique case (state_q)
      ST_IDLE: begin
        if ((img_number_in != img_q) && (&eng_done)) begin
          row_d      = '0;
          col_d      = '0;
          srch_d     = '0;
          row_base_d = RowStep;
          state_d    = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (|gnt) begin
          load  = gnt;
          ptr_d = (32'(gnt_idx) == NUM_ENG - 1) ? '0 : gnt_idx + 1'b1;
          if (col_q != LastCol) begin
            col_d  = col_q + 6'd1;
            srch_d = srch_q + SrchStep;
          end else begin
            col_d      = '0;
            row_d      = row_q + 6'd1;
            srch_d     = row_base_q;
            row_base_d = row_base_q + RowStep;
          end
          if ((row_q == LastRow) && (col_q == LastCol)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!(|pending_q) && !(|busy_q) && (&eng_done)) begin
          img_d        = img_q + 4'd1;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // eng_done falling acknowledges a start; rising again ends the job. Unsolicited lows
  // never touch the flags.
  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (pending_q[i] && !eng_done[i]) begin
        pending_d[i] = 1'b0;
        busy_d[i]    = 1'b1;
      end else if (busy_q[i] && eng_done[i]) begin
        busy_d[i] = 1'b0;
      end
      if (load[i]) pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      img_q        <= '0;
      frame_done_q <= 1'b0;
      ptr_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      srch_q       <= '0;
      row_base_q   <= '0;
      pending_q    <= '0;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      img_q        <= img_d;
      frame_done_q <= frame_done_d;
      ptr_q        <= ptr_d;
      row_q        <= row_d;
      col_q        <= col_d;
      srch_q       <= srch_d;
      row_base_q   <= row_base_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srch_addr_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      index_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (load[i]) begin
          srch_addr_q[i] <= {img_q[0], srch_q};
          left_q[i]      <= {img_q[0], srch_q + LeftOff};
          right_q[i]     <= {img_q[0], srch_q + RightOff};
          index_q[i]     <= {img_q, row_q, col_q};
        end
      end
    end
  end

  assign eng_start          = pending_q;
  assign frame_done         = frame_done_q;
  assign bm_working_buf     = img_q[0];
  assign sched_idle         = (state_q == ST_IDLE) && (&eng_done);
  assign eng_srch_addr      = srch_addr_q;
  assign eng_blk_addr_left  = left_q;
  assign eng_blk_addr_right = right_q;
  assign eng_blk_index      = index_q;

endmodule

// File: doc/bm_dispatch_sched.md
Name: bm_dispatch_sched

Overview:
- Frame-level scheduler that shares block-matching work across NUM_ENG parallel stereo block-match engines. Each engine is one left/right pair driven by a single start.
- Walks the block grid in raster order and dispatches each block, with its search/block addresses and result index, to the next ready engine, round-robin.
- Sits between the frame-buffer image counter and the engine array, replacing the single-engine sequencing FSM.
- Declares the frame complete only after every engine has drained.

Parameters:
- NUM_ENG, 2, number of engines; 1..8.
- rd_port_w, 8, bits per frame-buffer word.
- bit_frame_w, 960, frame width in pixels.
- bit_frame_h, 540, frame height in pixels.
- block_width, 16, block width in pixels.
- block_height, 16, block height in pixels.
- search_blk_w, 64, search window width in pixels.
- search_blk_h, 32, search window height in pixels.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- img_number_in  in  4  producer's image counter; new frame is ready when it differs from the internal img_number.
- sched_idle  out  1  high in ST_IDLE with all engines done.
- bm_working_buf  out  1  img_number[0].
- frame_done  out  1  one-cycle pulse when a frame completes.
- eng_done  in  NUM_ENG  per-engine level, high = idle/ready.
- eng_start  out  NUM_ENG  per-engine start, held until that engine's eng_done falls.
- eng_srch_addr  out  NUM_ENG*16  per-engine search address, {img_number[0], srch[14:0]}.
- eng_blk_addr_left  out  NUM_ENG*16  {img_number[0], srch+left_off}.
- eng_blk_addr_right  out  NUM_ENG*16  {img_number[0], srch+right_off}.
- eng_blk_index  out  NUM_ENG*16  {img_number, blk_row[5:0], blk_col[5:0]}.

Behaviour:
- Derived constants:
  - frame_addr_w = bit_frame_w/rd_port_w.
  - blk_addr_w = block_width/rd_port_w.
  - blocks_per_row = (bit_frame_w-search_blk_w)/block_width, 56 at defaults.
  - blocks_per_col = (bit_frame_h-search_blk_h)/block_height, 31 at defaults.
  - row_step = frame_addr_w*block_height, 1920 at defaults.
  - right_off = frame_addr_w*((search_blk_h-block_height)/2), 960 at defaults.
  - left_off = right_off + search_blk_w/rd_port_w - blk_addr_w, 966 at defaults.
- Address arithmetic: 15-bit, modulo 2^15; bit 15 is always the buffer select.
- Reset values (async, on reset_n low): state ST_IDLE, img_number 0, all eng_start 0, frame_done 0, rr pointer 0, row/col/address counters 0, all per-engine output registers 0.
- Per-engine status flags:
  - pending: start asserted, eng_done still high.
  - busy: eng_done has fallen after a start.
  - Engine is ready when eng_done=1 and pending=0.
  - pending clears when eng_done=0 is sampled; busy clears on eng_done=1.
  - eng_done low without a start is ignored and never counted.
- ST_IDLE: when img_number_in != img_number and all eng_done=1, clear counters (row=0, col=0, srch=0, row_base=row_step) and go to ST_DISPATCH.
  - img_number_in changes during ST_DISPATCH or ST_DRAIN are ignored; they are re-evaluated in ST_IDLE.
- ST_DISPATCH, per cycle:
  - At most one dispatch per cycle.
  - Grant goes to the ready engine nearest at or after the rr pointer; the pointer then moves to granted+1 mod NUM_ENG.
  - The granted engine's address and index registers are loaded and its eng_start goes high in the same edge. Outputs are registered: visible the cycle after grant.
  - Counter advance: if col < blocks_per_row-1, col++ and srch += blk_addr_w. Otherwise col=0, row++, srch = row_base, row_base += row_step.
  - Dispatching the last block (row = blocks_per_col-1, col = blocks_per_row-1) moves to ST_DRAIN.
  - No ready engine: hold, no state change.
- ST_DRAIN: when no engine is pending or busy and all eng_done=1:
  - img_number++, which wraps at 16.
  - frame_done pulses for 1 cycle.
  - Go to ST_IDLE.
- Per-engine outputs hold their values until that engine's next dispatch.
- Latency: from frame detect to first eng_start is 2 cycles.
- Minimum engine turnaround: 1 cycle after eng_done rises.

Decomposition:
- Package bm_sched_pkg holds:
  - the statetype enum (ST_IDLE, ST_DISPATCH, ST_DRAIN);
  - functions computing blocks_per_row, blocks_per_col, row_step, left_off and right_off from the parameters.
- Sub-module bm_rr_pick: combinational round-robin picker with inputs req[NUM_ENG] and ptr, outputs gnt one-hot and gnt_idx.

Test Plan:
- NUM_ENG=2, engines finish 5 cycles after start, img_number_in 0→1 → first grant to engine 0 with srch 0x0000, blk_left 966, blk_right 960, index 0x0000. Engine 1 gets col 1: srch 2, index 0x0001.
- Full frame, 2 engines → exactly 1736 starts total, with row wrap at col 55→0 (row 1: srch 1920, left 2886, right 2880). Then one frame_done pulse, img_number=1, bm_working_buf=1, and addresses for frame 2 carry bit15=1.
- Both engines ready in the same cycle → only one start per cycle, alternating 0,1,0,1. An engine with eng_done stuck low is never granted, and the frame stalls in ST_DRAIN until it rises.
- img_number_in toggled mid-frame → no restart. Counters keep advancing, and the new frame begins only after frame_done.
- reset_n asserted low mid-dispatch with eng_start high → all starts, frame_done and img_number are 0 immediately (asynchronous). After release, with img_number_in=1, the frame restarts at block (0,0).
